// File: rtl/apb_master.sv
// APB initiator: accepts one read/write command at a time, runs SETUP->ACCESS on the bus,
// and returns read data or a timeout error on a one-cycle response strobe.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 21,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_hit;

    // Abort on the wait cycle whose incremented count reaches TIMEOUT-1.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) >= (TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a wait-state-programmable APB slave plus a
// transaction-level model of latency, bus values, responses and timeout.
module tb_apb_master;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 21;
    localparam int TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    int checks = 0;
    int errors = 0;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // Slave: holds PREADY low for slave_waits ACCESS cycles; PRDATA is junk unless ready.
    int                slave_waits = 0;
    logic [DATA_W-1:0] slave_data  = '0;
    logic [DATA_W-1:0] junk        = '0;
    int                acc_cnt     = 0;

    always @(posedge PCLK) acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    always @(negedge PCLK) junk <= DATA_W'($urandom);
    assign PREADY = PSEL && PENABLE && (acc_cnt == slave_waits);
    assign PRDATA = PREADY ? slave_data : junk;

    // Held response values expected from the most recent completed transfer.
    logic [DATA_W-1:0] exp_rdata = '0;
    logic              exp_err   = 1'b0;

    // noise: 0 = cmd_valid low while busy, 1 = random junk commands, 2 = always valid.
    task automatic run_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input int waits,
                            input logic [DATA_W-1:0] sd, input int noise);
        logic              err;
        int                acc;
        logic [DATA_W-1:0] exp_pw;
        logic [DATA_W-1:0] rd;
        logic [3:0]        ctl_exp;
        err    = (TIMEOUT != 0) && (waits >= TIMEOUT - 1);
        acc    = err ? TIMEOUT - 1 : waits + 1;
        exp_pw = wr ? wd : '0;
        rd     = (err || wr) ? '0 : sd;

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_cmd got %b want 1", cmd_ready);
        end
        slave_waits = waits;
        slave_data  = sd;
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_addr    = addr;
        cmd_wdata   = wd;

        for (int k = 1; k <= acc + 2; k++) begin
            @(posedge PCLK); #1;
            cmd_valid = 1'b0;
            if (noise == 2 || (noise == 1 && $urandom_range(1, 0) == 1)) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom);
                cmd_addr  = ADDR_W'($urandom);
                cmd_wdata = DATA_W'($urandom);
            end
            ctl_exp = (k <= acc + 1) ? {1'b1, (k > 1), 1'b0, 1'b0} : 4'b0011;
            checks++;
            if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== ctl_exp) begin
                errors++;
                $display("FAIL ctl k=%0d acc=%0d {psel,pen,rdy,rspv} got %b want %b",
                         k, acc, {PSEL, PENABLE, cmd_ready, rsp_valid}, ctl_exp);
            end
            checks++;
            if ({PADDR, PWRITE, PWDATA} !== {addr, wr, exp_pw}) begin
                errors++;
                $display("FAIL bus k=%0d got a=%h w=%b d=%h want a=%h w=%b d=%h",
                         k, PADDR, PWRITE, PWDATA, addr, wr, exp_pw);
            end
            if (k <= acc + 1) begin
                checks++;
                if ({rsp_rdata, rsp_err} !== {exp_rdata, exp_err}) begin
                    errors++;
                    $display("FAIL rsp_hold k=%0d got %h/%b want %h/%b",
                             k, rsp_rdata, rsp_err, exp_rdata, exp_err);
                end
            end else begin
                checks++;
                if ({rsp_rdata, rsp_err} !== {rd, err}) begin
                    errors++;
                    $display("FAIL rsp got rdata=%h err=%b want rdata=%h err=%b",
                             rsp_rdata, rsp_err, rd, err);
                end
            end
        end
        cmd_valid = 1'b0;
        exp_rdata = rd;
        exp_err   = err;
    endtask

    task automatic test_reset();
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
        end
        checks++;
        if ({PADDR, PWRITE, PWDATA, rsp_rdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h w=%b d=%h r=%h e=%b want all 0",
                     PADDR, PWRITE, PWDATA, rsp_rdata, rsp_err);
        end
        PRESET = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_write_zero_wait();
        run_xfer(1'b1, 8'h2A, 21'h1ABCD, 0, 21'h0F0F0, 0);
    endtask

    task automatic test_read_wait_states();
        run_xfer(1'b0, 8'h05, 21'h1FFFF, 3, 21'h12345, 0);
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 8'h77, '0, 100, 21'h0AAAA, 0);
        run_xfer(1'b1, 8'h78, 21'h00055, 1, '0, 0);
    endtask

    task automatic test_ready_at_limit();
        run_xfer(1'b0, 8'h10, '0, TIMEOUT - 2, 21'h15A5A, 0);
        run_xfer(1'b0, 8'h11, '0, TIMEOUT - 1, 21'h0B0B0, 0);
        run_xfer(1'b0, 8'h12, '0, TIMEOUT - 3, 21'h1C3C3, 0);
    endtask

    task automatic test_reset_in_access();
        logic seen;
        slave_waits = 50;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 8'hC3;
        cmd_wdata   = 21'h1F00F;
        for (int k = 1; k <= 3; k++) begin
            @(posedge PCLK); #1;
            cmd_valid = 1'b0;
        end
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre_access got %b want 11", {PSEL, PENABLE});
        end
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        checks++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_ctl got %b want 0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
        end
        checks++;
        if ({PADDR, PWRITE, PWDATA} !== '0) begin
            errors++;
            $display("FAIL rst_mid_bus got a=%h w=%b d=%h want 0", PADDR, PWRITE, PWDATA);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge PCLK); #1;
            if (rsp_valid === 1'b1 || PSEL === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rsp got activity=%b want 0", seen);
        end
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, 8'h40, 21'h00123, 2, '0, 2);
        run_xfer(1'b0, 8'h41, '0, 0, 21'h1DEAD, 2);
        run_xfer(1'b0, 8'h42, '0, 5, 21'h0BEEF, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_xfer(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                     int'($urandom_range(20, 0)), DATA_W'($urandom), 1);
            if ($urandom_range(1, 0) == 1) begin
                @(posedge PCLK); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_timeout();
        test_ready_at_limit();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        @(posedge PCLK); #1;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b0, exp_rdata, exp_err}) begin
            errors++;
            $display("FAIL final_hold got v=%b r=%h e=%b want v=0 r=%h e=%b",
                     rsp_valid, rsp_rdata, rsp_err, exp_rdata, exp_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
